// File: rtl/carry_lookahead_adder_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared types and helpers for the carry-lookahead adder/
//                subtractor: lookahead group size, propagate/generate pair
//                and the associative propagate/generate combine operator.
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    // Width of one first-level lookahead block.
    localparam int CLA_GROUP = 4;

    // Propagate/generate pair for a bit span.
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Merge a higher-order span onto a lower-order span.
    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/carry_lookahead_adder_subtractor_cla_block_4.sv
`default_nettype none
// ============================================================================
//  Module      : cla_block_4
//  Description : 4-bit carry-lookahead block. Internal carries are fully
//                expanded sum-of-products (no ripple). Exports group
//                propagate/generate for the second-level lookahead.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_block_4
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       pg,
    output logic       gg,
    output logic       cout
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    // Bit propagate/generate, expanded carries, sums and group terms.
    always_comb begin
        w_p = a ^ b;
        w_g = a & b;

        w_c[0] = cin;
        w_c[1] = w_g[0]
               | (w_p[0] & cin);
        w_c[2] = w_g[1]
               | (w_p[1] & w_g[0])
               | (w_p[1] & w_p[0] & cin);
        w_c[3] = w_g[2]
               | (w_p[2] & w_g[1])
               | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & cin);
        w_c[4] = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

        s    = w_p ^ w_c[3:0];
        pg   = &w_p;
        gg   = w_g[3]
             | (w_p[3] & w_g[2])
             | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        cout = w_c[4];
    end

endmodule
`default_nettype wire

// File: rtl/carry_lookahead_adder_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : carry_lookahead_adder_subtractor
//  Description : Registered two's-complement adder/subtractor. control=0
//                gives A+B+Cin, control=1 gives A+~B+Cin. Two-level
//                carry lookahead, one-cycle latency, one op per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_lookahead_adder_subtractor
    import cla_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             control,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             ovf
);

    localparam int C_NUM_GROUPS = WIDTH / GROUP;

    // Refuse to elaborate a width the block structure cannot tile.
    if ((GROUP != CLA_GROUP) || (WIDTH < GROUP) || ((WIDTH % GROUP) != 0)) begin : g_width_check
        $error("carry_lookahead_adder_subtractor: WIDTH must be a non-zero multiple of GROUP=4");
    end

    logic [WIDTH-1:0]        w_bb;
    logic [WIDTH-1:0]        w_sum;
    logic [C_NUM_GROUPS-1:0] w_pg;
    logic [C_NUM_GROUPS-1:0] w_gg;
    logic [C_NUM_GROUPS-1:0] w_blk_cout;
    logic [C_NUM_GROUPS:0]   w_gc;
    logic                    w_c_msb;
    logic                    w_ovf;

    logic [WIDTH-1:0]        r_sum;
    logic                    r_cout;
    logic                    r_ovf;

    // Carry into group k computed directly from all lower groups and Cin,
    // so no group waits on its neighbour's carry.
    function automatic logic f_group_carry(
        input int                      k,
        input logic [C_NUM_GROUPS-1:0] pg,
        input logic [C_NUM_GROUPS-1:0] gg,
        input logic                    cin
    );
        pg_t acc;
        acc.p = 1'b0;
        acc.g = cin;
        for (int j = 0; j < C_NUM_GROUPS; j++) begin
            if (j < k) begin
                acc = pg_combine(pg_t'{p: pg[j], g: gg[j]}, acc);
            end
        end
        return acc.g;
    endfunction

    assign w_bb    = B ^ {WIDTH{control}};
    assign w_gc[0] = Cin;

    for (genvar k = 0; k < C_NUM_GROUPS; k++) begin : g_groups
        cla_block_4 u_blk (
            .a    (A[k*GROUP +: GROUP]),
            .b    (w_bb[k*GROUP +: GROUP]),
            .cin  (w_gc[k]),
            .s    (w_sum[k*GROUP +: GROUP]),
            .pg   (w_pg[k]),
            .gg   (w_gg[k]),
            .cout (w_blk_cout[k])
        );
    end

    for (genvar k = 1; k <= C_NUM_GROUPS; k++) begin : g_lookahead
        assign w_gc[k] = f_group_carry(k, w_pg, w_gg, Cin);
    end

    // Signed overflow: carry into the MSB recovered from its sum bit,
    // compared with the carry leaving the top block.
    assign w_c_msb = w_sum[WIDTH-1] ^ A[WIDTH-1] ^ w_bb[WIDTH-1];
    assign w_ovf   = w_c_msb ^ w_blk_cout[C_NUM_GROUPS-1];

    // Output register stage; reset clears the result and drops any in-flight op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_gc[C_NUM_GROUPS];
            r_ovf  <= w_ovf;
        end
    end

    assign sum  = r_sum;
    assign Cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_carry_lookahead_adder_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_carry_lookahead_adder_subtractor
//  Description : Self-checking bench for the 4-bit registered CLA
//                adder/subtractor: directed table, reset sequences,
//                exhaustive back-to-back sweep and random vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_lookahead_adder_subtractor;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       control;
    logic [3:0] sum;
    logic       Cout;
    logic       ovf;

    int checks;
    int failures;

    carry_lookahead_adder_subtractor #(.WIDTH(4), .GROUP(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .Cin     (Cin),
        .control (control),
        .sum     (sum),
        .Cout    (Cout),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       ctl;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic cin, input logic ctl);
        int ua, ub, u, sa, sb, s;
        logic [3:0] rs;
        logic rc, ro;
        ua = int'(a);
        ub = ctl ? (15 - int'(b)) : int'(b);
        u  = ua + ub + int'(cin);
        rs = 4'(u % 16);
        rc = (u > 15);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        s  = sa + sb + int'(cin);
        ro = (s > 7) || (s < -8);
        return {ro, rc, rs};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic ctl, input logic rn);
        @(negedge clk);
        A = a; B = b; Cin = cin; control = ctl; rst_n = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [3:0] es,
                             input logic ec, input logic eo);
        check({name, ".sum"},  32'(sum),  32'(es));
        check({name, ".cout"}, 32'(Cout), 32'(ec));
        check({name, ".ovf"},  32'(ovf),  32'(eo));
    endtask

    vec_t vecs[7];
    logic [5:0] exp6;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; A = 4'hF; B = 4'hF; Cin = 1'b1; control = 1'b0;

        vecs[0] = '{"add_3_5",     4'h3, 4'h5, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[1] = '{"add_wrap",    4'hF, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0};
        vecs[2] = '{"sub_A_A",     4'hA, 4'hA, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[3] = '{"sub_5_7",     4'h5, 4'h7, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0};
        vecs[4] = '{"sub_0_0",     4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[5] = '{"sub_0_0_bin", 4'h0, 4'h0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0};
        vecs[6] = '{"sub_ovf",     4'h8, 4'h1, 1'b1, 1'b1, 4'h7, 1'b1, 1'b1};

        // Reset held two cycles with all-ones operands.
        drive(4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        check_out("reset_c1", 4'h0, 1'b0, 1'b0);
        drive(4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        check_out("reset_c2", 4'h0, 1'b0, 1'b0);

        // Directed table, first entry applied on release.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].ctl, 1'b1);
            check_out(vecs[i].name, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        // Reset after a non-zero result clears it immediately.
        drive(4'h7, 4'h7, 1'b1, 1'b0, 1'b1);
        check_out("pre_reset", 4'hF, 1'b0, 1'b1);
        drive(4'h7, 4'h7, 1'b1, 1'b0, 1'b0);
        check_out("mid_reset", 4'h0, 1'b0, 1'b0);
        drive(4'h2, 4'h3, 1'b0, 1'b0, 1'b1);
        check_out("post_reset", 4'h5, 1'b0, 1'b0);

        // Exhaustive sweep back-to-back, reset pulsed for one vector.
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] v;
            logic       rn;
            v  = 10'(i);
            rn = (i != 517);
            drive(v[3:0], v[7:4], v[8], v[9], rn);
            exp6 = rn ? model(v[3:0], v[7:4], v[8], v[9]) : 6'b0;
            check(rn ? "sweep" : "sweep_reset", 32'({ovf, Cout, sum}), 32'(exp6));
        end

        // Random vectors.
        for (int i = 0; i < 200; i++) begin
            logic [9:0] r;
            r = 10'($urandom);
            drive(r[3:0], r[7:4], r[8], r[9], 1'b1);
            exp6 = model(r[3:0], r[7:4], r[8], r[9]);
            check("random", 32'({ovf, Cout, sum}), 32'(exp6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
